// File: rtl/param_array_sorter.sv
// Buffers up to MAX_ARRAY_SIZE words, sorts them in place with an odd-even transposition network, then streams them out.
// Latency: first output beat appears array_size cycles after the sort-accept edge; then one beat per accepted transfer.
// Backpressure: loads stall via add_ready outside IDLE or when full; output data/valid/last hold while ready_in is low.
module param_array_sorter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ARRAY_SIZE = 16,
  localparam int CW            = $clog2(MAX_ARRAY_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  add_element,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  add_ready,
  input  logic                  sort_array,
  input  logic                  descending,
  input  logic                  signed_mode,
  input  logic                  clear_array,
  output logic [DATA_WIDTH-1:0] sorted_data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         array_size,
  output logic                  full,
  output logic                  overflow
);

  localparam int AW = $clog2(MAX_ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, SORT, OUTPUT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           size_q, size_d;
  logic [CW-1:0]           phase_q, phase_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic                    desc_q, desc_d;
  logic                    sgn_q, sgn_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [DATA_WIDTH-1:0]   mem_q [MAX_ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]   mem_d [MAX_ARRAY_SIZE];
  logic [CW-1:0]           idx_inc;

  // True when a (earlier) must move behind b (later) under the latched mode; equal values never swap.
  function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b,
                                        input logic desc, input logic sgn);
    logic gt, lt;
    if (sgn) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return desc ? lt : gt;
  endfunction

  assign full            = (size_q == CW'(MAX_ARRAY_SIZE));
  assign add_ready       = (state_q == IDLE) && !full && !sort_array && !clear_array;
  assign busy            = (state_q != IDLE);
  assign valid_out       = valid_q;
  assign last_out        = last_q;
  assign done            = done_q;
  assign overflow        = ovf_q;
  assign array_size      = size_q;
  assign sorted_data_out = dout_q;

  // Next-state logic: load, compare-exchange phases, output stream; clear overrides everything.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    desc_d  = desc_q;
    sgn_d   = sgn_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    mem_d   = mem_q;
    idx_inc = idx_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (clear_array) begin
          size_d = '0;
          ovf_d  = 1'b0;
        end else if (sort_array) begin
          if (size_q == '0) begin
            done_d = 1'b1;
          end else begin
            desc_d  = descending;
            sgn_d   = signed_mode;
            phase_d = '0;
            state_d = SORT;
          end
        end else if (add_element) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            mem_d[size_q[AW-1:0]] = data_in;
            size_d                = size_q + CW'(1);
          end
        end
      end

      SORT: begin
        // Pairs within a phase are disjoint, so every exchange reads only mem_q.
        for (int i = 0; i < MAX_ARRAY_SIZE - 1; i++) begin
          if ((i[0] == phase_q[0]) && (i + 1 < int'(size_q)) &&
              out_of_order(mem_q[i], mem_q[i+1], desc_q, sgn_q)) begin
            mem_d[i]   = mem_q[i+1];
            mem_d[i+1] = mem_q[i];
          end
        end
        if (phase_q == size_q - CW'(1)) begin
          state_d = OUTPUT;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (size_q == CW'(1));
          dout_d  = mem_d[0];
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end

      OUTPUT: begin
        if (ready_in) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            dout_d = mem_q[idx_inc[AW-1:0]];
            last_d = (idx_inc == size_q - CW'(1));
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (clear_array) begin
      state_d = IDLE;
      size_d  = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= '0;
      phase_q <= '0;
      idx_q   <= '0;
      desc_q  <= 1'b0;
      sgn_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      desc_q  <= desc_d;
      sgn_q   <= sgn_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  // Element storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
